spi_resp_arbiter: RTL and testbench
===================================

// Module: spi_resp_arbiter
// PURPOSE
//  Round-robin arbiter that shares the SPI minion's single outbound (to-host) val/rdy stream
//  between NREQ on-chip producers: classifier result, async-FIFO readback, status.
//  Registers the winning payload with its requester index as a tag, so the host can demux
//  responses. Flags a sticky error if the SPI side stalls a held response too long.
//  Sits between the producers and the SPI minion adapter in the chip top; single clock domain.
// PARAMETERS
//  NREQ       3    number of requesters (2..8)
//  DATA_W     16   payload width per requester
//  TAG_W      4    tag width; must satisfy 2**TAG_W >= NREQ
//  STALL_MAX  1024 held-cycles before stall_err sets (>=2)
// PORTS
//  clk        in   1              system clock
//  reset      in   1              reset: asynchronous, active-low
//  req_msg    in   NREQ*DATA_W    payloads; requester i at [i*DATA_W +: DATA_W]
//  req_val    in   NREQ           per-requester valid
//  req_rdy    out  NREQ           per-requester ready (one-hot or zero)
//  cfg_mask   in   NREQ           1 = requester enabled for arbitration
//  send_msg   out  TAG_W+DATA_W   {tag, payload} to SPI minion
//  send_val   out  1              output valid
//  send_rdy   in   1              SPI minion ready
//  stall_clr  in   1              synchronous clear of stall_err
//  stall_err  out  1              sticky: held response waited >= STALL_MAX cycles
//  busy       out  1              = send_val (output register occupied)
// BEHAVIOUR
//  - Reset (reset==0, async): send_val=0, send_msg=0, rr_ptr=0, stall_cnt=0, stall_err=0.
//  - eligible[i] = req_val[i] & cfg_mask[i]. can_accept = !send_val | send_rdy.
//  - Winner: first eligible index scanning rr_ptr, rr_ptr+1, ... NREQ-1, 0, ... (wrap).
//  - req_rdy[i] = can_accept & any_eligible & (i==winner); all others 0. Masked requester
//    never sees rdy. Requesters must not derive req_val from req_rdy.
//  - Accept (req_val[w]&req_rdy[w]) at edge: send_msg <= {TAG_W'(w), payload_w}, send_val<=1,
//    rr_ptr <= (w==NREQ-1) ? 0 : w+1.
//  - Output fire (send_val&send_rdy) without accept: send_val<=0; send_msg holds last value.
//  - Fire and accept same cycle: new message loaded, send_val stays 1 -> 1 msg/cycle sustained.
//  - send_msg stable while send_val & !send_rdy; later cfg_mask changes never touch held msg.
//  - Latency: accept at edge N -> send_val high from N (visible cycle N+1); no comb path
//    req_msg -> send_msg.
//  - rr_ptr changes only on accept; idle cycles leave it unchanged.
//  - State (2): EMPTY (send_val=0) / FULL (send_val=1). EMPTY->FULL on accept;
//    FULL->EMPTY on fire w/o accept; FULL->FULL on fire+accept or no fire.
//  - stall_cnt: +1 each cycle send_val & !send_rdy, saturating at STALL_MAX; cleared to 0 on
//    fire or when send_val=0. stall_err <= 1 when stall_cnt reaches STALL_MAX-1 and still
//    stalled (i.e. STALL_MAX-th stalled cycle). Held until stall_clr=1 (stall_clr wins over set
//    in same cycle only if not stalled that cycle; if both, stall_err stays 1).
//  - cfg_mask=0 or all req_val=0: no accepts; held output still drains normally.
//  - Reset mid-transfer: held message discarded, send_val drops immediately (async).
// TESTING
//  1 Reset: assert reset=0 mid-hold -> send_val=0, send_msg=0, stall_err=0 same cycle; rr_ptr=0.
//  2 All 3 val=1 constantly, send_rdy=1, mask=3'b111 -> grant order 0,1,2,0,1,2; one msg/cycle,
//    send_msg tags 0,1,2 with matching payloads (e.g. 16'hA000+i).
//  3 Backpressure: send_rdy=0 for 5 cycles with req0 val (16'h1234) -> send_msg=20'h0_1234 stable,
//    req_rdy=0 throughout; send_rdy=1 -> fire, next winner loaded same edge.
//  4 Mask: mask=3'b101, all val=1 -> grants alternate 0,2; req_rdy[1] never 1.
//  5 Stall: STALL_MAX=8, send_rdy=0 with msg held -> stall_err rises on 8th stalled cycle;
//    stays after send_rdy=1; stall_clr pulse -> 0. 7-cycle stall -> stall_err stays 0.
//  6 Single requester 2 only, then req0 -> rr_ptr wraps 0 after grant 2; req0 granted next.

Source files
------------

// File: rtl/spi_resp_arbiter.sv
// Round-robin arbiter sharing one outbound val/rdy stream between NREQ producers.
// The winning payload is registered with its requester index as a tag; a sticky flag reports long stalls.
module spi_resp_arbiter #(
    parameter int NREQ      = 3,
    parameter int DATA_W    = 16,
    parameter int TAG_W     = 4,
    parameter int STALL_MAX = 1024
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ*DATA_W-1:0]  req_msg,
    input  logic [NREQ-1:0]         req_val,
    output logic [NREQ-1:0]         req_rdy,
    input  logic [NREQ-1:0]         cfg_mask,
    output logic [TAG_W+DATA_W-1:0] send_msg,
    output logic                    send_val,
    input  logic                    send_rdy,
    input  logic                    stall_clr,
    output logic                    stall_err,
    output logic                    busy
);

    localparam int PTR_W = $clog2(NREQ);
    localparam int CNT_W = $clog2(STALL_MAX + 1);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t             state;
    state_t             state_next;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   win;
    logic [PTR_W:0]     scan;
    logic [NREQ-1:0]    eligible;
    logic               any_eligible;
    logic               can_accept;
    logic               accept;
    logic               stalled;
    logic               stall_hit;
    logic [CNT_W-1:0]   stall_cnt;
    logic [DATA_W-1:0]  win_payload;

    assign eligible     = req_val & cfg_mask;
    assign any_eligible = |eligible;
    assign send_val     = (state == FULL);
    assign busy         = send_val;
    assign can_accept   = !send_val || send_rdy;
    assign accept       = can_accept && any_eligible;
    assign stalled      = send_val && !send_rdy;
    assign stall_hit    = stalled && (stall_cnt >= CNT_W'(STALL_MAX - 1));
    assign win_payload  = req_msg[win*DATA_W +: DATA_W];

    // Scan offsets from the highest down so the lowest offset from rr_ptr wins.
    always_comb begin
        win  = '0;
        scan = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            scan = {1'b0, rr_ptr} + (PTR_W+1)'(k);
            if (scan >= (PTR_W+1)'(NREQ))
                scan = scan - (PTR_W+1)'(NREQ);
            if (eligible[scan[PTR_W-1:0]])
                win = scan[PTR_W-1:0];
        end
    end

    always_comb begin
        req_rdy = '0;
        for (int i = 0; i < NREQ; i++)
            req_rdy[i] = accept && (win == PTR_W'(i));
    end

    always_comb begin
        state_next = state;
        case (state)
            EMPTY:   if (accept) state_next = FULL;
            FULL:    if (send_rdy && !accept) state_next = EMPTY;
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= EMPTY;
            rr_ptr <= '0;
        end else begin
            state <= state_next;
            if (accept)
                rr_ptr <= (win == PTR_W'(NREQ - 1)) ? '0 : win + 1'b1;
        end
    end

    // Held message only changes on a new accept, so cfg_mask edits cannot disturb it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            send_msg <= '0;
        else if (accept)
            send_msg <= {TAG_W'(win), win_payload};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
            stall_err <= 1'b0;
        end else begin
            if (!stalled)
                stall_cnt <= '0;
            else if (stall_cnt != CNT_W'(STALL_MAX))
                stall_cnt <= stall_cnt + 1'b1;
            // A stalled cycle that reaches the limit overrides a simultaneous clear.
            if (stall_hit)
                stall_err <= 1'b1;
            else if (stall_clr)
                stall_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_spi_resp_arbiter.sv
// Bench for spi_resp_arbiter: reference model checked every cycle plus directed literal expectations.
module tb_spi_resp_arbiter;

    localparam int NREQ      = 3;
    localparam int DATA_W    = 16;
    localparam int TAG_W     = 4;
    localparam int STALL_MAX = 8;
    localparam int MW        = TAG_W + DATA_W;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [NREQ*DATA_W-1:0] req_msg;
    logic [NREQ-1:0]        req_val;
    logic [NREQ-1:0]        req_rdy;
    logic [NREQ-1:0]        cfg_mask;
    logic [MW-1:0]          send_msg;
    logic                   send_val;
    logic                   send_rdy;
    logic                   stall_clr;
    logic                   stall_err;
    logic                   busy;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    spi_resp_arbiter #(
        .NREQ(NREQ), .DATA_W(DATA_W), .TAG_W(TAG_W), .STALL_MAX(STALL_MAX)
    ) dut (
        .clk(clk), .reset(reset), .req_msg(req_msg), .req_val(req_val),
        .req_rdy(req_rdy), .cfg_mask(cfg_mask), .send_msg(send_msg),
        .send_val(send_val), .send_rdy(send_rdy), .stall_clr(stall_clr),
        .stall_err(stall_err), .busy(busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] msg_of(input int tag, input logic [15:0] payload);
        return (32'(tag) << DATA_W) | 32'(payload);
    endfunction

    // Reference model: queue-free single slot, winner by modular distance from the pointer.
    bit            m_val;
    bit            m_err;
    logic [MW-1:0] m_msg;
    int            m_ptr;
    int            m_cnt;
    int            m_w;
    bit            m_stalled;

    function automatic int pick(input logic [NREQ-1:0] elig, input int ptr);
        for (int d = 0; d < NREQ; d++)
            if (elig[(ptr + d) % NREQ]) return (ptr + d) % NREQ;
        return -1;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_val = 0; m_err = 0; m_msg = '0; m_ptr = 0; m_cnt = 0;
        end else begin
            m_w       = pick(req_val & cfg_mask, m_ptr);
            m_stalled = m_val && !send_rdy;
            if (m_stalled && m_cnt >= STALL_MAX - 1) m_err = 1;
            else if (stall_clr) m_err = 0;
            m_cnt = m_stalled ? ((m_cnt + 1 > STALL_MAX) ? STALL_MAX : m_cnt + 1) : 0;
            if ((!m_val || send_rdy) && m_w >= 0) begin
                m_msg = MW'(msg_of(m_w, req_msg[m_w*DATA_W +: DATA_W]));
                m_val = 1;
                m_ptr = (m_w + 1) % NREQ;
            end else if (m_val && send_rdy) begin
                m_val = 0;
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        int w;
        logic [NREQ-1:0] exp_rdy;
        w = pick(req_val & cfg_mask, m_ptr);
        exp_rdy = (w >= 0 && (!m_val || send_rdy)) ? NREQ'(1 << w) : '0;
        check("mdl_req_rdy", 32'(req_rdy), 32'(exp_rdy));
        check("mdl_send_val", 32'(send_val), 32'(m_val));
        check("mdl_send_msg", 32'(send_msg), 32'(m_msg));
        check("mdl_stall_err", 32'(stall_err), 32'(m_err));
        check("mdl_busy", 32'(busy), 32'(m_val));
    end

    task automatic set_payloads(input logic [15:0] p0, input logic [15:0] p1, input logic [15:0] p2);
        req_msg = {p2, p1, p0};
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; req_val = '0; cfg_mask = 3'b111; send_rdy = 1'b0; stall_clr = 1'b0;
        set_payloads(16'hA000, 16'hA001, 16'hA002);
        @(negedge clk);
        check("rst_send_val", 32'(send_val), 0);
        check("rst_send_msg", 32'(send_msg), 0);
        check("rst_stall_err", 32'(stall_err), 0);
        #2 reset = 1'b1;

        // Round robin over all three at full throughput
        req_val = 3'b111; send_rdy = 1'b1;
        #1 check("t2_first_rdy", 32'(req_rdy), 32'b001);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("t2_msg", 32'(send_msg), msg_of(k % 3, 16'hA000 + 16'(k % 3)));
            check("t2_val", 32'(send_val), 1);
            check("t2_rdy", 32'(req_rdy), 32'(1 << ((k + 1) % 3)));
        end
        #2 req_val = '0;
        @(negedge clk);
        check("t2_drain_val", 32'(send_val), 0);
        check("t2_drain_hold", 32'(send_msg), msg_of(2, 16'hA002));

        // Backpressure holds the message and blocks grants
        #2 set_payloads(16'h1234, 16'h5555, 16'hA002); req_val = 3'b001; send_rdy = 1'b0;
        @(negedge clk);
        check("t3_load", 32'(send_msg), 32'h0_1234);
        #2 req_val = 3'b011;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("t3_hold_msg", 32'(send_msg), 32'h0_1234);
            check("t3_hold_rdy", 32'(req_rdy), 0);
            check("t3_no_err", 32'(stall_err), 0);
        end
        #2 send_rdy = 1'b1;
        #1 check("t3_release_rdy", 32'(req_rdy), 32'b010);
        @(negedge clk);
        check("t3_next_msg", 32'(send_msg), 32'h1_5555);
        check("t3_next_val", 32'(send_val), 1);
        #2 req_val = '0;
        @(negedge clk);
        check("t3_drain_val", 32'(send_val), 0);

        // Masked requester 1 never granted
        #2 set_payloads(16'hA000, 16'hA001, 16'hA002); cfg_mask = 3'b101; req_val = 3'b111;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("t4_msg", 32'(send_msg), msg_of((k % 2 == 0) ? 2 : 0, (k % 2 == 0) ? 16'hA002 : 16'hA000));
            check("t4_rdy1", 32'(req_rdy[1]), 0);
        end
        #2 req_val = '0; cfg_mask = 3'b111;
        @(negedge clk);
        check("t4_drain_val", 32'(send_val), 0);

        // Stall of STALL_MAX cycles sets the sticky flag
        #2 req_val = 3'b001; send_rdy = 1'b0;
        @(negedge clk);
        check("t5_load_val", 32'(send_val), 1);
        #2 req_val = '0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check("t5_err_ramp", 32'(stall_err), (k == 8) ? 1 : 0);
        end
        #2 send_rdy = 1'b1;
        @(negedge clk);
        check("t5_err_sticky", 32'(stall_err), 1);
        check("t5_fired", 32'(send_val), 0);
        #2 stall_clr = 1'b1;
        @(negedge clk);
        check("t5_err_clr", 32'(stall_err), 0);
        #2 stall_clr = 1'b0; req_val = 3'b001; send_rdy = 1'b0;
        @(negedge clk);
        #2 req_val = '0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            check("t5_short_stall", 32'(stall_err), 0);
        end
        #2 send_rdy = 1'b1;
        @(negedge clk);
        check("t5_short_after", 32'(stall_err), 0);

        // Pointer wraps to 0 after granting the last requester
        #2 req_val = 3'b100;
        #1 check("t6_rdy2", 32'(req_rdy), 32'b100);
        @(negedge clk);
        check("t6_msg2", 32'(send_msg), msg_of(2, 16'hA002));
        #2 req_val = 3'b011;
        #1 check("t6_rdy0", 32'(req_rdy), 32'b001);
        @(negedge clk);
        check("t6_msg0", 32'(send_msg), msg_of(0, 16'hA000));
        #2 req_val = '0;
        @(negedge clk);

        // Asynchronous reset while a stalled message is held
        #2 req_val = 3'b001; send_rdy = 1'b0;
        @(negedge clk);
        #2 req_val = '0;
        repeat (9) @(negedge clk);
        check("t1_err_before", 32'(stall_err), 1);
        #2 reset = 1'b0;
        #1;
        check("t1_val", 32'(send_val), 0);
        check("t1_msg", 32'(send_msg), 0);
        check("t1_err", 32'(stall_err), 0);
        check("t1_busy", 32'(busy), 0);
        req_val = 3'b111; send_rdy = 1'b1;
        #1 check("t1_ptr0_rdy", 32'(req_rdy), 32'b001);
        @(negedge clk);
        check("t1_held_in_reset", 32'(send_val), 0);
        #2 reset = 1'b1;
        @(negedge clk);
        check("t1_first_after", 32'(send_msg), msg_of(0, 16'hA000));
        #2 req_val = '0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
